// File: rtl/uart_rx.sv
// UART receiver: 8N1, 16x oversampling, 2-flop input synchronizer.
// Define UART_RX_FRAME_ERR_EN to enable the rx_frame_err pulse on a bad stop bit.
module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err
);

  localparam int OS_DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nx;
  logic              rx_meta, rx_s;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [3:0]        tick_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              stop_hold;
  logic [1:0]        settle;
  logic              armed;
  logic              start_go, shift_en, ld_byte, bad_stop;

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // A start needs a genuine high-to-low edge: after reset, wait for the
  // synchronizer to flush and the line to be seen high before arming.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      if (!settle[1]) settle <= settle + 2'd1;
      if (state == IDLE && settle[1] && rx_s) armed <= 1'b1;
    end
  end

  assign tick = (div_cnt == DIV_W'(OS_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)                  div_cnt <= '0;
    else if (start_go || tick)   div_cnt <= '0;
    else                         div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start_go = 1'b0;
    shift_en = 1'b0;
    ld_byte  = 1'b0;
    bad_stop = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !rx_s) begin
          state_nx = START;
          start_go = 1'b1;
        end
      end
      START: begin
        if (tick && tick_cnt == 4'd7) state_nx = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick && tick_cnt == 4'd15) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        // After a bad stop bit, park here until the line returns high.
        if (stop_hold) begin
          if (rx_s) state_nx = IDLE;
        end else if (tick && tick_cnt == 4'd15) begin
          if (rx_s) begin
            ld_byte  = 1'b1;
            state_nx = IDLE;
          end else begin
            bad_stop = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Tick and bit counters restart on every state change; tick_cnt wraps
  // mod 16 between data bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
    end else if (state_nx != state) begin
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
    end else begin
      if (tick && state != IDLE) tick_cnt <= tick_cnt + 4'd1;
      if (shift_en)              bit_cnt  <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift     <= 8'h00;
      stop_hold <= 1'b0;
    end else begin
      if (shift_en)              shift <= {rx_s, shift[7:1]};
      if (bad_stop)              stop_hold <= 1'b1;
      else if (state_nx != STOP) stop_hold <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= ld_byte;
      if (ld_byte) rx_data <= shift;
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) rx_frame_err <= 1'b0;
    else        rx_frame_err <= bad_stop;
  end
`else
  assign rx_frame_err = 1'b0;
`endif

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int CLK_HALF = 5;
  localparam int BIT_T    = 160;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, rx_frame_err;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_busy(rx_busy), .rx_frame_err(rx_frame_err)
  );

  always #CLK_HALF clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (rx_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got data %0h expected no pulse", rx_data);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        if (rx_data !== e) begin
          errors++;
          $display("FAIL rx_data: got %0h expected %0h", rx_data, e);
        end
      end
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL valid_width: got 2+ cycle pulse expected 1");
      end
    end
    if (rx_valid && rx_frame_err) begin
      errors++;
      $display("FAIL valid_and_err: got both high expected exclusive");
    end
    if (rx_frame_err) err_seen++;
    prev_valid = rx_valid;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop, input int bt);
    rx = 1'b0;
    #bt;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #bt;
    end
    rx = stop;
    #bt;
  endtask

  // Reference model: a well-formed frame yields exactly its byte.
  task automatic send_good(input logic [7:0] b, input int bt);
    exp_q.push_back(b);
    last_good = b;
    send_byte(b, 1'b1, bt);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    int e0;
    repeat (4) @(negedge clk);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_valid", rx_valid, 0);
    chk("reset_busy", rx_busy, 0);
    chk("reset_err", rx_frame_err, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // nominal 0x55
    fork
      send_good(8'h55, BIT_T);
      begin #(BIT_T * 4); chk("busy_mid_frame", rx_busy, 1); end
    join
    drain("drain_55");
    chk("err_after_55", err_seen, 0);

    // back-to-back stream as from a transmitter
    send_good(8'hA5, BIT_T);
    send_good(8'h00, BIT_T);
    send_good(8'hFF, BIT_T);
    drain("drain_b2b");

    // short glitch: no frame, busy clears quickly
    repeat (20) @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    begin
      int n = 0;
      while (rx_busy !== 1'b0 && n < 10) begin @(negedge clk); n++; end
      chk("glitch_busy_clear", rx_busy, 0);
    end
    repeat (20) @(negedge clk);
    chk("glitch_no_err", err_seen, 0);

    // bad stop bit followed by a break
    e0 = err_seen;
    send_byte(8'h3C, 1'b0, BIT_T);
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
`ifdef UART_RX_FRAME_ERR_EN
    chk("break_err_pulses", err_seen - e0, 1);
`else
    chk("break_err_pulses", err_seen - e0, 0);
`endif
    chk("break_data_kept", rx_data, last_good);
    chk("break_idle", rx_busy, 0);

    // reset during data bit 4 of 0x81, then a clean 0x7E
    repeat (5) @(negedge clk);
    fork
      send_byte(8'h81, 1'b1, BIT_T);
      begin
        #(BIT_T * 5 + BIT_T / 2);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        chk("midreset_data", rx_data, 8'h00);
        chk("midreset_busy", rx_busy, 0);
      end
    join
    repeat (8) @(negedge clk);
    send_good(8'h7E, BIT_T);
    drain("drain_7E");
    chk("data_7E", rx_data, 8'h7E);

    // skewed bit periods on 0xC3
    send_good(8'hC3, BIT_T + 5);
    drain("drain_C3_slow");
    send_good(8'hC3, BIT_T - 5);
    drain("drain_C3_fast");

    // random bytes, random skew and gaps
    for (int k = 0; k < 20; k++) begin
      automatic int sk = $urandom_range(2);
      automatic int gap = $urandom_range(3);
      send_good(8'($urandom), BIT_T - 5 + 5 * sk);
      if (gap != 0) #(gap * 10 * CLK_HALF * 2);
    end
    drain("drain_random");
    repeat (40) @(negedge clk);
`ifndef UART_RX_FRAME_ERR_EN
    chk("no_err_overall", err_seen, 0);
`endif
    chk("final_idle", rx_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(2_000_000);
    $display("FAIL timeout: got no completion expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz, SHALL be provided.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate in baud, SHALL be provided.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 Port rx, input, 1 bit: asynchronous serial line, idle high; it SHALL be compatible with the uart_tx frame (1 start bit, 8 data bits LSB first, 1 stop bit).
REQ-006 Port rx_data, output, 8 bits: last correctly received byte.
REQ-007 Port rx_valid, output, 1 bit: one-cycle pulse indicating rx_data has been updated.
REQ-008 Port rx_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 Port rx_frame_err, output, 1 bit: one-cycle pulse indicating a stop-bit violation.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer before use; the synchronizer flops SHALL reset to 1.
REQ-011 The oversample tick SHALL fire once every OS_DIV = CLK_FREQ/(BAUD_RATE*16) clocks (651 at default parameters), using a free-running divider that restarts at 0 on a START entry.
REQ-012 The state machine SHALL have four states: IDLE, START, DATA, STOP.
REQ-013 In IDLE, a synchronized rx of 0 SHALL cause a move to START with the tick and sample counters cleared.
REQ-014 In START, the line SHALL be sampled on the 8th tick (mid-bit): a value of 1 is a false start and SHALL return to IDLE with no pulse; a value of 0 SHALL move to DATA.
REQ-015 In DATA, the line SHALL be sampled every 16 ticks and the sample shifted into the shift register LSB first; after the 8th bit the state SHALL move to STOP.
REQ-016 In STOP, sampling on the 16th tick SHALL behave as follows: 1 loads rx_data from the shift register, pulses rx_valid for exactly one clk cycle on the next clock, and moves to IDLE.
REQ-017 If the STOP sample is 0, no rx_valid SHALL be produced, rx_data SHALL be unchanged, and behaviour then depends on REQ-023/REQ-024.
REQ-018 rx_data SHALL hold its value until the next valid frame; rx_valid and rx_frame_err SHALL never be high simultaneously.
REQ-019 Back-to-back frames (a stop bit followed immediately by a start edge) SHALL be received without loss.
REQ-020 A sustained low line (break) SHALL NOT produce repeated frames: after a bad stop bit the block SHALL remain in STOP until synchronized rx reads 1.

Reset
REQ-021 When rst_n = 0 at a clk edge, the block SHALL enter IDLE and set rx_data = 0x00, rx_valid = 0, rx_busy = 0, rx_frame_err = 0, and all counters = 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, the block SHALL wait for a new falling edge (line high to low).

Configuration
REQ-023 With macro UART_RX_FRAME_ERR_EN defined, a bad stop bit SHALL pulse rx_frame_err for one cycle when the 0 is sampled.
REQ-024 Without UART_RX_FRAME_ERR_EN, rx_frame_err SHALL be tied to 0, and a bad stop bit SHALL still suppress rx_valid and still hold in STOP per REQ-020.

Verification (CLK_FREQ=1_600_000, BAUD_RATE=100_000, so 16 clocks per bit)
REQ-025 Serial 0x55 at nominal timing -> one rx_valid pulse, rx_data = 0x55, rx_frame_err = 0.
REQ-026 Loopback from uart_tx (same parameters), sending 0xA5, then 0x00, then 0xFF back-to-back -> three rx_valid pulses with rx_data 0xA5, 0x00, 0xFF in that order.
REQ-027 A 4-clock low glitch on an idle line -> no rx_valid, no rx_frame_err, and rx_busy returns to 0 within 10 clocks.
REQ-028 0x3C sent with the stop bit forced to 0, then the line held low for 40 clocks and released -> with the macro: exactly one rx_frame_err pulse, no rx_valid, rx_data unchanged; without the macro: no pulses at all.
REQ-029 rst_n driven low for 1 cycle during data bit 4 of 0x81, followed by a clean 0x7E -> no pulse for the aborted frame, then rx_data = 0x7E.
REQ-030 Bit period skewed by +/-3% (±~0.5 clock per bit, accumulated over the frame) on 0xC3 -> rx_data = 0xC3.
